// File: rtl/barrel_pkg.sv
// Shared types and constants for the shift command issue stage and its shifter.
package barrel_pkg;

    localparam int DATA_W = 16;
    localparam int AMT_W  = 4;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [AMT_W-1:0]  amt;
        logic [1:0]        op;
    } shift_cmd_t;

endpackage

// File: rtl/barrelshifter16.sv
// Combinational 16-bit barrel shifter: SLL, SRL, SRA and rotate-right.
module barrelshifter16
    import barrel_pkg::*;
(
    input  logic [DATA_W-1:0] i0,
    input  logic [AMT_W-1:0]  s,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] o
);

    logic [2*DATA_W-1:0] w_rot;

    // Select the shift flavour; rotate uses a doubled operand so the low half wraps around.
    always_comb begin
        o     = {DATA_W{1'b0}};
        w_rot = {i0, i0} >> s;
        case (op)
            OP_SLL:  o = i0 << s;
            OP_SRL:  o = i0 >> s;
            OP_SRA:  o = DATA_W'($signed(i0) >>> s);
            OP_ROR:  o = w_rot[DATA_W-1:0];
            default: o = {DATA_W{1'b0}};
        endcase
    end

endmodule

// File: rtl/shift_cmd_fifo.sv
// Command FIFO: DEPTH entries (any DEPTH >= 2), wrap-around pointers and occupancy count.
module shift_cmd_fifo
    import barrel_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  shift_cmd_t    i_wdata,
    output shift_cmd_t    o_rdata,
    output logic [CW-1:0] o_count,
    output logic          o_full,
    output logic          o_empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    shift_cmd_t    r_mem [DEPTH];

    logic w_push;
    logic w_pop;

    // Pointers step to the next slot and wrap explicitly, so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    // Pointer and occupancy bookkeeping; reset discards all queued entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents need no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

endmodule

// File: rtl/shift_cmd_issue.sv
// Shift command front-end: buffers commands, feeds the FIFO head to an external
// barrel shifter and captures its result into a valid/ready output register.
module shift_cmd_issue
    import barrel_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [1:0]        in_op,
    output logic [DATA_W-1:0] sh_i0,
    output logic [AMT_W-1:0]  sh_s,
    output logic [1:0]        sh_op,
    input  logic [DATA_W-1:0] sh_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_op,
    output logic [CW-1:0]     count
);

    shift_cmd_t        w_wcmd;
    shift_cmd_t        w_head;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_load;

    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [1:0]        r_out_op;

    // Acceptance looks only at the registered count: a pop in the same cycle does not free a slot early.
    assign in_ready = !w_full;
    assign w_push   = in_valid && !w_full;
    assign w_wcmd   = '{data: in_data, amt: in_amt, op: in_op};
    assign w_load   = !w_empty && (!r_out_valid || out_ready);

    shift_cmd_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_load),
        .i_wdata (w_wcmd),
        .o_rdata (w_head),
        .o_count (count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Drive the shifter from the FIFO head, or all zeros while the queue is empty.
    always_comb begin
        sh_i0 = {DATA_W{1'b0}};
        sh_s  = {AMT_W{1'b0}};
        sh_op = 2'b00;
        if (!w_empty) begin
            sh_i0 = w_head.data;
            sh_s  = w_head.amt;
            sh_op = w_head.op;
        end else begin
            sh_i0 = {DATA_W{1'b0}};
            sh_s  = {AMT_W{1'b0}};
            sh_op = 2'b00;
        end
    end

    // Output register: capture the shifter result on load, drop valid once drained, hold under backpressure.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {DATA_W{1'b0}};
            r_out_op    <= 2'b00;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= sh_o;
            r_out_op    <= w_head.op;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_op    = r_out_op;

endmodule
